// File: rtl/systolic_skew_feeder_if.sv
// Handshake and data bundle between the operand source, the skew feeder and the array edge.
// slave = feeder side, master = source/sink side.
interface systolic_skew_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 4,
    parameter int CNT_WIDTH  = 8
);
    logic                                  start;
    logic [CNT_WIDTH-1:0]                  num_vec;
    logic                                  in_valid;
    logic                                  in_ready;
    logic [0:LENGTH-1][DATA_WIDTH-1:0]     data_in;
    logic                                  busy;
    logic                                  done;
    logic [LENGTH-1:0]                     out_valid;
    logic [0:LENGTH-1][DATA_WIDTH-1:0]     data_out;

    modport slave (
        input  start, num_vec, in_valid, data_in,
        output in_ready, busy, done, out_valid, data_out
    );

    modport master (
        output start, num_vec, in_valid, data_in,
        input  in_ready, busy, done, out_valid, data_out
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Diagonal skew feeder: lane i of each accepted vector appears i cycles after lane 0.
// Optional macro FEEDER_ZERO_GATE_EN forces invalid output lanes to zero.
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    systolic_skew_feeder_if.slave  bus
);
    localparam int                   DRN_W     = (LENGTH > 2) ? $clog2(LENGTH - 1) : 1;
    localparam logic [DRN_W-1:0]     DRN_LAST  = DRN_W'((LENGTH > 1) ? LENGTH - 2 : 0);
    localparam logic [DRN_W-1:0]     DRN_ONE   = DRN_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN
    } state_t;

    state_t                 state_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   num_vec_q;
    logic [DRN_W-1:0]       drn_q;
    logic                   in_ready_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   accept;
    logic                   last_vec;

    logic [LENGTH-1:0]                 lane_vld;
    logic [0:LENGTH-1][DATA_WIDTH-1:0] lane_dat;

    // in_ready is a register, so accept has no combinational path back to in_valid.
    assign accept   = bus.in_valid && in_ready_q;
    assign last_vec = (cnt_q == (num_vec_q - CNT_ONE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            num_vec_q  <= '0;
            drn_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start && (bus.num_vec != '0)) begin
                        state_q    <= S_FEED;
                        num_vec_q  <= bus.num_vec;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_FEED: begin
                    if (accept) begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (last_vec) begin
                            in_ready_q <= 1'b0;
                            if (LENGTH == 1) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_DRAIN;
                                drn_q   <= '0;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    // Last drain edge is exactly when the final element lands on lane LENGTH-1.
                    if (drn_q == DRN_LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drn_q <= drn_q + DRN_ONE;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < LENGTH; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] dat_q [0:i];
        logic [i:0]            vld_q;

        // Data shifts every cycle; the valid bit travels with it so bubbles stay diagonal.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int k = 0; k <= i; k++) begin
                    dat_q[k] <= '0;
                end
                vld_q <= '0;
            end else begin
                dat_q[0] <= bus.data_in[i];
                vld_q[0] <= accept;
                for (int k = 1; k <= i; k++) begin
                    dat_q[k] <= dat_q[k-1];
                    vld_q[k] <= vld_q[k-1];
                end
            end
        end

        assign lane_vld[i] = vld_q[i];
`ifdef FEEDER_ZERO_GATE_EN
        assign lane_dat[i] = vld_q[i] ? dat_q[i] : '0;
`else
        assign lane_dat[i] = dat_q[i];
`endif
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_valid = lane_vld;
    assign bus.data_out  = lane_dat;

endmodule
